// File: rtl/llc_request_arbiter_if.sv
// ----------------------------------------------------------------------------
// llc_request_arbiter_if
// Handshake bundle between the two LLC requesters, the request arbiter and
// the cache command port.
//
// Signals:
//   cpu_req/cpu_cmd/cpu_addr -> CPU/trace request, held until cpu_ack
//   cpu_ack                  <- one-cycle accept pulse for the CPU side
//   snp_req/snp_cmd/snp_addr -> snoop request, held until snp_ack
//   snp_ack                  <- one-cycle accept pulse for the snoop side
//   llc_valid/cmd/addr       <- command presented to the cache
//   llc_ready                -> cache takes the command this cycle
//   llc_done                 -> cache finished the accepted command
//   err_illegal              <- pulse with the ack of a dropped request
//   busy                     <- arbiter is not idle
//
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters and cache)
// ----------------------------------------------------------------------------
interface llc_request_arbiter_if #(
  parameter int CMD_W  = 4,
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic [CMD_W-1:0]  cpu_cmd;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic              snp_req;
  logic [CMD_W-1:0]  snp_cmd;
  logic [ADDR_W-1:0] snp_addr;
  logic              snp_ack;
  logic              llc_valid;
  logic [CMD_W-1:0]  llc_cmd;
  logic [ADDR_W-1:0] llc_addr;
  logic              llc_ready;
  logic              llc_done;
  logic              err_illegal;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_cmd, cpu_addr,
    output cpu_ack,
    input  snp_req, snp_cmd, snp_addr,
    output snp_ack,
    output llc_valid, llc_cmd, llc_addr,
    input  llc_ready, llc_done,
    output err_illegal, busy
  );

  modport master (
    output cpu_req, cpu_cmd, cpu_addr,
    input  cpu_ack,
    output snp_req, snp_cmd, snp_addr,
    input  snp_ack,
    input  llc_valid, llc_cmd, llc_addr,
    output llc_ready, llc_done,
    input  err_illegal, busy
  );
endinterface

// File: rtl/llc_request_arbiter.sv
// ----------------------------------------------------------------------------
// llc_request_arbiter
// Shares the single command/address port of the last-level cache between a
// CPU/trace requester and a snoop requester. Only one transaction is ever
// outstanding. Snoops win arbitration, except that a waiting CPU request is
// forced through after STARVE_LIMIT consecutive snoop grants. Requests with
// an illegal command code are acknowledged, flagged on err_illegal and never
// forwarded to the cache.
//
// Ports:
//   clk   : clock, everything on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : llc_request_arbiter_if.slave (requesters, cache port, status)
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module llc_request_arbiter #(
  parameter int CMD_W        = 4,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  llc_request_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DROP      = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // CPU/trace legal codes: read, write, instruction read, CLEAR, PRINT.
  function automatic logic cpu_cmd_legal(input logic [CMD_W-1:0] cmd);
    logic legal;
    case (cmd)
      CMD_W'(0), CMD_W'(1), CMD_W'(2), CMD_W'(8), CMD_W'(9): legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Snoop legal codes: invalidate, read, write, RdX.
  function automatic logic snp_cmd_legal(input logic [CMD_W-1:0] cmd);
    logic legal;
    case (cmd)
      CMD_W'(3), CMD_W'(4), CMD_W'(5), CMD_W'(6): legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;

  logic              cpu_ack_r;
  logic              snp_ack_r;
  logic              llc_valid_r;
  logic [CMD_W-1:0]  llc_cmd_r;
  logic [ADDR_W-1:0] llc_addr_r;
  logic              err_r;
  logic              busy_r;
  logic [3:0]        starve_cnt_r;

  logic              cpu_ack_nxt_s;
  logic              snp_ack_nxt_s;
  logic              llc_valid_nxt_s;
  logic [CMD_W-1:0]  llc_cmd_nxt_s;
  logic [ADDR_W-1:0] llc_addr_nxt_s;
  logic              err_nxt_s;
  logic              busy_nxt_s;
  logic [3:0]        starve_nxt_s;

  logic              starve_hit_s;
  logic              pick_snp_s;
  logic              pick_cpu_s;
  logic              grant_s;
  logic              legal_s;
  logic [CMD_W-1:0]  sel_cmd_s;
  logic [ADDR_W-1:0] sel_addr_s;

  // Arbitration decode: who would win if the FSM is idle this cycle.
  always_comb begin
    starve_hit_s = bus.cpu_req && (starve_cnt_r >= LIMIT);
    pick_snp_s   = bus.snp_req && !starve_hit_s;
    pick_cpu_s   = bus.cpu_req && !pick_snp_s;
    grant_s      = pick_snp_s || pick_cpu_s;
    if (pick_snp_s) begin
      sel_cmd_s  = bus.snp_cmd;
      sel_addr_s = bus.snp_addr;
      legal_s    = snp_cmd_legal(bus.snp_cmd);
    end else begin
      sel_cmd_s  = bus.cpu_cmd;
      sel_addr_s = bus.cpu_addr;
      legal_s    = cpu_cmd_legal(bus.cpu_cmd);
    end
  end

  // Next-state logic of the transaction FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          if (legal_s) begin
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s = DROP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        // A cache that completes in the accept cycle skips WAIT_DONE.
        if (bus.llc_ready) begin
          if (bus.llc_done) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT_DONE;
          end
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (bus.llc_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      DROP: begin
        // One cycle so the requester has retired its request before re-arbitration.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output logic: next values of every registered output and the starvation counter.
  always_comb begin
    cpu_ack_nxt_s   = 1'b0;
    snp_ack_nxt_s   = 1'b0;
    err_nxt_s       = 1'b0;
    llc_valid_nxt_s = 1'b0;
    llc_cmd_nxt_s   = llc_cmd_r;
    llc_addr_nxt_s  = llc_addr_r;
    starve_nxt_s    = starve_cnt_r;
    busy_nxt_s      = (state_nxt_s != IDLE);
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          cpu_ack_nxt_s   = pick_cpu_s;
          snp_ack_nxt_s   = pick_snp_s;
          err_nxt_s       = !legal_s;
          llc_valid_nxt_s = legal_s;
          if (legal_s) begin
            llc_cmd_nxt_s  = sel_cmd_s;
            llc_addr_nxt_s = sel_addr_s;
          end else begin
            llc_cmd_nxt_s  = llc_cmd_r;
            llc_addr_nxt_s = llc_addr_r;
          end
          // Count only snoop wins that make a CPU request wait; saturate at 15.
          if (pick_snp_s && bus.cpu_req) begin
            if (starve_cnt_r == 4'hF) begin
              starve_nxt_s = starve_cnt_r;
            end else begin
              starve_nxt_s = starve_cnt_r + 4'd1;
            end
          end else begin
            starve_nxt_s = 4'd0;
          end
        end else begin
          starve_nxt_s = starve_cnt_r;
        end
      end
      ISSUE: begin
        // Hold the command until the cache takes it.
        llc_valid_nxt_s = !bus.llc_ready;
      end
      WAIT_DONE: begin
        llc_valid_nxt_s = 1'b0;
      end
      DROP: begin
        llc_valid_nxt_s = 1'b0;
      end
      default: begin
        llc_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, output and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cpu_ack_r    <= 1'b0;
      snp_ack_r    <= 1'b0;
      llc_valid_r  <= 1'b0;
      llc_cmd_r    <= '0;
      llc_addr_r   <= '0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      cpu_ack_r    <= cpu_ack_nxt_s;
      snp_ack_r    <= snp_ack_nxt_s;
      llc_valid_r  <= llc_valid_nxt_s;
      llc_cmd_r    <= llc_cmd_nxt_s;
      llc_addr_r   <= llc_addr_nxt_s;
      err_r        <= err_nxt_s;
      busy_r       <= busy_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  assign bus.cpu_ack     = cpu_ack_r;
  assign bus.snp_ack     = snp_ack_r;
  assign bus.llc_valid   = llc_valid_r;
  assign bus.llc_cmd     = llc_cmd_r;
  assign bus.llc_addr    = llc_addr_r;
  assign bus.err_illegal = err_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_llc_request_arbiter.sv
// ----------------------------------------------------------------------------
// tb_llc_request_arbiter
// Directed bench for llc_request_arbiter. Stimulus pushes the hand-computed
// grant (source, error flag, command, address) into a queue; a monitor pops
// and compares whenever an ack appears. A small cache responder answers
// llc_valid with programmable ready/done delays. Timing-specific checks are
// made inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_llc_request_arbiter;
  localparam int CMD_W        = 4;
  localparam int ADDR_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  llc_request_arbiter_if #(.CMD_W(CMD_W), .ADDR_W(ADDR_W)) bus ();

  llc_request_arbiter #(
    .CMD_W(CMD_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic              is_snp;
    logic              err;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   rdy_delay  = 0;
  int   done_delay = 1;
  int   snp_grants = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_grant(input logic is_snp, input logic err,
                              input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.is_snp = is_snp;
    e.err    = err;
    e.cmd    = cmd;
    e.addr   = addr;
    exp_q.push_back(e);
  endtask

  task automatic cpu_request(input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr);
    bit got;
    got = 1'b0;
    bus.cpu_cmd  = cmd;
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) got = 1'b1;
    end
    check("cpu_ack_seen", 64'(got), 64'd1);
    bus.cpu_req = 1'b0;
  endtask

  task automatic snp_request(input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr);
    bit got;
    got = 1'b0;
    bus.snp_cmd  = cmd;
    bus.snp_addr = addr;
    bus.snp_req  = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.snp_ack === 1'b1) got = 1'b1;
    end
    check("snp_ack_seen", 64'(got), 64'd1);
    if (got) snp_grants++;
    bus.snp_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) idle = 1'b1;
    end
    check("idle_reached", 64'(idle), 64'd1);
    @(negedge clk);
  endtask

  // Scoreboard monitor: every ack pops one expected grant.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (bus.cpu_ack === 1'b1 || bus.snp_ack === 1'b1)) begin
        if (bus.cpu_ack === 1'b1 && bus.snp_ack === 1'b1) begin
          n_cmp++;
          n_bad++;
          $display("FAIL both_acks: actual=cpu_ack=1,snp_ack=1 required=one ack (t=%0t)", $time);
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: actual snp_ack=%0b cmd=0x%0h required=no grant (t=%0t)",
                   bus.snp_ack, bus.llc_cmd, $time);
        end else begin
          e = exp_q.pop_front();
          check("grant_source_is_snp", 64'(bus.snp_ack), 64'(e.is_snp));
          check("err_illegal", 64'(bus.err_illegal), 64'(e.err));
          check("llc_valid_with_ack", 64'(bus.llc_valid), 64'(!e.err));
          if (!e.err) begin
            check("llc_cmd", 64'(bus.llc_cmd), 64'(e.cmd));
            check("llc_addr", 64'(bus.llc_addr), 64'(e.addr));
          end
        end
      end else if (rst_n === 1'b1 && bus.err_illegal === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL err_without_ack: actual=1 required=0 (t=%0t)", $time);
      end
    end
  end

  // Cache responder: ready after rdy_delay cycles, done done_delay cycles after ready.
  initial begin : cache
    bus.llc_ready = 1'b0;
    bus.llc_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.llc_valid === 1'b1) begin
        repeat (rdy_delay) @(negedge clk);
        bus.llc_ready = 1'b1;
        if (done_delay == 0) bus.llc_done = 1'b1;
        @(negedge clk);
        bus.llc_ready = 1'b0;
        bus.llc_done  = 1'b0;
        if (done_delay > 0) begin
          repeat (done_delay - 1) @(negedge clk);
          bus.llc_done = 1'b1;
          @(negedge clk);
          bus.llc_done = 1'b0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    int cnt;
    rst_n        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_cmd  = '0;
    bus.cpu_addr = '0;
    bus.snp_req  = 1'b0;
    bus.snp_cmd  = '0;
    bus.snp_addr = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cpu_ack", 64'(bus.cpu_ack), 64'd0);
    check("rst_snp_ack", 64'(bus.snp_ack), 64'd0);
    check("rst_llc_valid", 64'(bus.llc_valid), 64'd0);
    check("rst_llc_cmd", 64'(bus.llc_cmd), 64'd0);
    check("rst_llc_addr", 64'(bus.llc_addr), 64'd0);
    check("rst_err", 64'(bus.err_illegal), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_starve", 64'(dut.starve_cnt_r), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU only: ready with the ack, done two cycles later, idle at N+4
    rdy_delay  = 0;
    done_delay = 2;
    expect_grant(1'b0, 1'b0, 4'd1, 32'h0000_1040);
    cpu_request(4'd1, 32'h0000_1040);
    check("cpu_only_busy_n1", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("cpu_only_valid_n2", 64'(bus.llc_valid), 64'd0);
    check("cpu_only_busy_n2", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("cpu_only_busy_n3", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("cpu_only_busy_n4", 64'(bus.busy), 64'd0);

    // Simultaneous requests: snoop first, CPU on the next arbitration
    done_delay = 1;
    expect_grant(1'b1, 1'b0, 4'd4, 32'h0000_2000);
    expect_grant(1'b0, 1'b0, 4'd0, 32'h0000_3000);
    fork
      cpu_request(4'd0, 32'h0000_3000);
      snp_request(4'd4, 32'h0000_2000);
    join
    check("simul_starve_after_cpu", 64'(dut.starve_cnt_r), 64'd0);
    wait_idle();

    // Starvation: four snoops pass a waiting CPU, the fifth grant is the CPU
    snp_grants = 0;
    for (int i = 0; i < 4; i++)
      expect_grant(1'b1, 1'b0, 4'(3 + i), 32'h0000_4000 + 32'(i) * 32'h40);
    expect_grant(1'b0, 1'b0, 4'd1, 32'h0000_5000);
    expect_grant(1'b1, 1'b0, 4'd3, 32'h0000_4100);
    fork
      begin
        cpu_request(4'd1, 32'h0000_5000);
        check("starve_snoops_before_cpu", 64'(snp_grants), 64'd4);
        check("starve_cnt_after_cpu", 64'(dut.starve_cnt_r), 64'd0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          snp_request(4'(3 + (i % 4)), 32'h0000_4000 + 32'(i) * 32'h40);
          check("starve_cnt_after_snoop", 64'(dut.starve_cnt_r), (i < 4) ? 64'(i + 1) : 64'd0);
        end
      end
    join
    wait_idle();

    // Illegal codes: ack + err together, no llc_valid, one DROP cycle
    expect_grant(1'b0, 1'b1, 4'd7, 32'h0000_6000);
    cpu_request(4'd7, 32'h0000_6000);
    check("illegal_cpu_busy_drop", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("illegal_cpu_busy_after", 64'(bus.busy), 64'd0);
    check("illegal_cpu_valid_after", 64'(bus.llc_valid), 64'd0);
    expect_grant(1'b1, 1'b1, 4'd1, 32'h0000_6100);
    snp_request(4'd1, 32'h0000_6100);
    check("illegal_snp_busy_drop", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("illegal_snp_busy_after", 64'(bus.busy), 64'd0);
    check("illegal_snp_valid_after", 64'(bus.llc_valid), 64'd0);
    @(negedge clk);

    // Backpressure: ready low for 5 cycles, a new snoop waits for llc_done
    rdy_delay  = 5;
    done_delay = 1;
    expect_grant(1'b0, 1'b0, 4'd2, 32'h0000_7000);
    cpu_request(4'd2, 32'h0000_7000);
    expect_grant(1'b1, 1'b0, 4'd5, 32'h0000_7100);
    bus.snp_cmd  = 4'd5;
    bus.snp_addr = 32'h0000_7100;
    bus.snp_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_valid_held", 64'(bus.llc_valid), 64'd1);
      check("bp_cmd_held", 64'(bus.llc_cmd), 64'd2);
      check("bp_addr_held", 64'(bus.llc_addr), 64'h0000_7000);
      check("bp_snp_blocked", 64'(bus.snp_ack), 64'd0);
      @(negedge clk);
    end
    check("bp_valid_dropped", 64'(bus.llc_valid), 64'd0);
    cnt = 0;
    while (bus.snp_ack !== 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("bp_snp_ack_delay", 64'(cnt), 64'd2);
    bus.snp_req = 1'b0;
    rdy_delay   = 0;
    wait_idle();

    // Reset during WAIT_DONE, then a normal grant
    done_delay = 3;
    expect_grant(1'b0, 1'b0, 4'd8, 32'hDEAD_BEEC);
    cpu_request(4'd8, 32'hDEAD_BEEC);
    @(negedge clk);
    check("rst_mid_busy_wait", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_cpu_ack", 64'(bus.cpu_ack), 64'd0);
    check("rst_mid_snp_ack", 64'(bus.snp_ack), 64'd0);
    check("rst_mid_llc_valid", 64'(bus.llc_valid), 64'd0);
    check("rst_mid_llc_cmd", 64'(bus.llc_cmd), 64'd0);
    check("rst_mid_llc_addr", 64'(bus.llc_addr), 64'd0);
    check("rst_mid_err", 64'(bus.err_illegal), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_state_idle", 64'(dut.state_r), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_mid_done_ignored", 64'(bus.busy), 64'd0);
    done_delay = 1;
    expect_grant(1'b1, 1'b0, 4'd6, 32'h0000_8000);
    snp_request(4'd6, 32'h0000_8000);
    wait_idle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
